// File: rtl/calc_pkg.sv
// calc_pkg: op codes shared with the entry FSM's 3-bit op field, and the
// execute-stage state encoding.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CONV,
        ST_EXEC,
        ST_DABBLE,
        ST_DONE
    } calc_state_t;

endpackage

// File: rtl/calc_execute_seq_dabble.sv
// bcd_double_dabble: sequential binary-to-BCD converter (shift-and-add-3).
// Ports:
//   i_Clk, i_Rst_n  clock, synchronous active-low reset
//   load            start a conversion of bin
//   bin             binary input, BIN_WIDTH bits
//   bcd             BCD digits, RESULT_DIGITS nibbles
//   valid           high for one cycle, exactly BIN_WIDTH cycles after load
module bcd_double_dabble #(
    parameter int BIN_WIDTH     = 14,
    parameter int RESULT_DIGITS = 4
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         load,
    input  logic [BIN_WIDTH-1:0]         bin,
    output logic [4*RESULT_DIGITS-1:0]   bcd,
    output logic                         valid
);

    localparam int SW = 4*RESULT_DIGITS + BIN_WIDTH;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    logic [SW-1:0] shift_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int d = 0; d < RESULT_DIGITS; d++) begin
            if (t[BIN_WIDTH + 4*d +: 4] >= 4'd5)
                t[BIN_WIDTH + 4*d +: 4] = t[BIN_WIDTH + 4*d +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    // The first shift happens on the load edge itself, so the last of the
    // BIN_WIDTH shifts lands just before the valid cycle.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (load) begin
            shift_q  <= dabble_step({{(4*RESULT_DIGITS){1'b0}}, bin});
            cnt_q    <= CW'(BIN_WIDTH - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                shift_q <= dabble_step(shift_q);
                cnt_q   <= cnt_q - 1'b1;
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign bcd   = shift_q[SW-1 -: 4*RESULT_DIGITS];
    assign valid = active_q && (cnt_q == '0);

endmodule

// File: rtl/calc_execute_seq.sv
// calc_execute_seq: calculator execute stage. Latches two BCD operands and an
// op, validates them, converts to binary, runs add/sub/shift-add multiply and
// converts the result back to BCD, then pulses o_Done for one cycle.
// Ports:
//   i_Clk, i_Rst_n             clock, synchronous active-low reset
//   i_Start                    request pulse, sampled only in IDLE
//   i_Operand_A, i_Operand_B   BCD operands, MS digit in top nibble
//   i_Op                       OP_ADD / OP_SUB / OP_MUL
//   o_Busy, o_Done             status; o_Done is a one-cycle pulse
//   o_Result_BCD, o_Negative, o_Error   registered on entry to DONE, held
//
// state  | meaning
// IDLE   | waiting for i_Start
// CHECK  | validate digits and op
// CONV   | BCD operands to binary
// EXEC   | add/sub (1 cycle) or shift-add multiply (MUL_BITS cycles)
// DABBLE | binary result to BCD
// DONE   | o_Done pulse, result visible
module calc_execute_seq
    import calc_pkg::*;
#(
    parameter int OPERAND_DIGITS = 2,
    parameter int RESULT_DIGITS  = 4,
    parameter int MUL_BITS       = 7,
    parameter int BIN_WIDTH      = 14
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic                        i_Start,
    input  logic [4*OPERAND_DIGITS-1:0] i_Operand_A,
    input  logic [4*OPERAND_DIGITS-1:0] i_Operand_B,
    input  logic [2:0]                  i_Op,
    output logic                        o_Busy,
    output logic                        o_Done,
    output logic [4*RESULT_DIGITS-1:0]  o_Result_BCD,
    output logic                        o_Negative,
    output logic                        o_Error
);

    localparam int OW  = 4*OPERAND_DIGITS;
    localparam int RW  = 4*RESULT_DIGITS;
    localparam int MCW = $clog2(MUL_BITS + 1);

    calc_state_t state_q, state_d;

    logic [OW-1:0]        a_bcd_q, b_bcd_q;
    logic [2:0]           op_q;
    logic [BIN_WIDTH-1:0] op_a_q;     // multiplicand, shifted left during multiply
    logic [MUL_BITS-1:0]  op_b_q;     // multiplier, shifted right during multiply
    logic [BIN_WIDTH-1:0] acc_q;
    logic [MCW-1:0]       mul_cnt_q;
    logic                 neg_q;
    logic [RW-1:0]        result_q;
    logic                 negative_q;
    logic                 error_q;

    logic                 check_err;
    logic [BIN_WIDTH-1:0] mul_sum;
    logic                 dd_load;
    logic [BIN_WIDTH-1:0] dd_bin;
    logic [RW-1:0]        dd_bcd;
    logic                 dd_valid;

    function automatic logic bcd_ok(input logic [OW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < OPERAND_DIGITS; k++)
            if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [MUL_BITS-1:0] bcd_to_bin(input logic [OW-1:0] v);
        logic [MUL_BITS-1:0] r;
        r = '0;
        for (int k = OPERAND_DIGITS - 1; k >= 0; k--)
            r = r * MUL_BITS'(10) + MUL_BITS'(v[4*k +: 4]);
        return r;
    endfunction

    assign check_err = !bcd_ok(a_bcd_q) || !bcd_ok(b_bcd_q) ||
                       !(op_q == OP_ADD || op_q == OP_SUB || op_q == OP_MUL);
    assign mul_sum   = acc_q + (op_b_q[0] ? op_a_q : '0);

    bcd_double_dabble #(
        .BIN_WIDTH     (BIN_WIDTH),
        .RESULT_DIGITS (RESULT_DIGITS)
    ) u_dabble (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .load    (dd_load),
        .bin     (dd_bin),
        .bcd     (dd_bcd),
        .valid   (dd_valid)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dd_load = 1'b0;
        dd_bin  = '0;
        o_Busy  = 1'b0;
        o_Done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                o_Busy  = 1'b1;
                state_d = check_err ? ST_DONE : ST_CONV;
            end
            ST_CONV: begin
                o_Busy  = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                o_Busy = 1'b1;
                if (op_q == OP_MUL) begin
                    // Last partial product is folded in combinationally so the
                    // converter starts on the final multiply cycle.
                    if (mul_cnt_q == '0) begin
                        dd_load = 1'b1;
                        dd_bin  = mul_sum;
                        state_d = ST_DABBLE;
                    end
                end else begin
                    dd_load = 1'b1;
                    if (op_q == OP_ADD)
                        dd_bin = op_a_q + BIN_WIDTH'(op_b_q);
                    else if (op_a_q >= BIN_WIDTH'(op_b_q))
                        dd_bin = op_a_q - BIN_WIDTH'(op_b_q);
                    else
                        dd_bin = BIN_WIDTH'(op_b_q) - op_a_q;
                    state_d = ST_DABBLE;
                end
            end
            ST_DABBLE: begin
                o_Busy = 1'b1;
                if (dd_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_Done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            a_bcd_q    <= '0;
            b_bcd_q    <= '0;
            op_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            acc_q      <= '0;
            mul_cnt_q  <= '0;
            neg_q      <= 1'b0;
            result_q   <= '0;
            negative_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        a_bcd_q <= i_Operand_A;
                        b_bcd_q <= i_Operand_B;
                        op_q    <= i_Op;
                    end
                end
                ST_CHECK: begin
                    if (check_err) begin
                        result_q   <= '0;
                        negative_q <= 1'b0;
                        error_q    <= 1'b1;
                    end
                end
                ST_CONV: begin
                    op_a_q    <= BIN_WIDTH'(bcd_to_bin(a_bcd_q));
                    op_b_q    <= bcd_to_bin(b_bcd_q);
                    acc_q     <= '0;
                    mul_cnt_q <= MCW'(MUL_BITS - 1);
                end
                ST_EXEC: begin
                    neg_q <= (op_q == OP_SUB) && (op_a_q < BIN_WIDTH'(op_b_q));
                    if (op_q == OP_MUL) begin
                        acc_q  <= mul_sum;
                        op_a_q <= op_a_q << 1;
                        op_b_q <= op_b_q >> 1;
                        if (mul_cnt_q != '0) mul_cnt_q <= mul_cnt_q - 1'b1;
                    end
                end
                ST_DABBLE: begin
                    if (dd_valid) begin
                        result_q   <= dd_bcd;
                        negative_q <= neg_q;
                        error_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_Result_BCD = result_q;
    assign o_Negative   = negative_q;
    assign o_Error      = error_q;

endmodule

// File: tb/tb_calc_execute_seq.sv
module tb_calc_execute_seq;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Operand_A = '0;
    logic [7:0]  i_Operand_B = '0;
    logic [2:0]  i_Op = '0;
    logic        o_Busy, o_Done, o_Negative, o_Error;
    logic [15:0] o_Result_BCD;

    int checks = 0;
    int errors = 0;

    calc_execute_seq dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_Start      (i_Start),
        .i_Operand_A  (i_Operand_A),
        .i_Operand_B  (i_Operand_B),
        .i_Op         (i_Op),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Result_BCD (o_Result_BCD),
        .o_Negative   (o_Negative),
        .o_Error      (o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        neg;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal arithmetic on the operand values, BCD via div/mod.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        vec_t v;
        int ia, ib, r;
        v.a = a; v.b = b; v.op = op; v.neg = 1'b0;
        if (a[7:4] > 9 || a[3:0] > 9 || b[7:4] > 9 || b[3:0] > 9 || op == 0 || op > 3) begin
            v.res = 16'h0000; v.err = 1'b1; v.lat = 2;
        end else begin
            ia = a[7:4] * 10 + a[3:0];
            ib = b[7:4] * 10 + b[3:0];
            if (op == 3'd1) r = ia + ib;
            else if (op == 3'd2) begin
                if (ia >= ib) r = ia - ib;
                else begin r = ib - ia; v.neg = 1'b1; end
            end else r = ia * ib;
            v.res = 16'(((r / 1000) % 10) * 4096 + ((r / 100) % 10) * 256 + ((r / 10) % 10) * 16 + r % 10);
            v.err = 1'b0;
            v.lat = (op == 3'd3) ? 24 : 18;
        end
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_op(input string tag, input vec_t v, input bit noise);
        int lat;
        i_Operand_A = v.a; i_Operand_B = v.b; i_Op = v.op; i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        lat = 1;
        check({tag, "_busy"}, 32'(o_Busy), 32'(1));
        while (!o_Done && lat < 60) begin
            if (noise && lat >= 3) begin
                i_Start = 1'b1;
                i_Operand_A = 8'($urandom); i_Operand_B = 8'($urandom); i_Op = 3'($urandom);
            end
            @(negedge i_Clk);
            lat++;
        end
        if (noise) begin
            i_Start = 1'b1;
            i_Operand_A = 8'($urandom); i_Operand_B = 8'($urandom); i_Op = 3'($urandom);
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.lat));
        check({tag, "_res"}, 32'(o_Result_BCD), 32'(v.res));
        check({tag, "_neg"}, 32'(o_Negative), 32'(v.neg));
        check({tag, "_err"}, 32'(o_Error), 32'(v.err));
        @(negedge i_Clk);
        i_Start = 1'b0;
        check({tag, "_pulse"}, {30'd0, o_Done, o_Busy}, 32'(0));
        check({tag, "_hold"}, 32'(o_Result_BCD), 32'(v.res));
    endtask

    initial begin
        vec_t v;
        int seen;

        vecs[0] = '{8'h45, 8'h37, 3'b001, 16'h0082, 1'b0, 1'b0, 18};
        vecs[1] = '{8'h12, 8'h57, 3'b010, 16'h0045, 1'b1, 1'b0, 18};
        vecs[2] = '{8'h05, 8'h05, 3'b010, 16'h0000, 1'b0, 1'b0, 18};
        vecs[3] = '{8'h99, 8'h99, 3'b011, 16'h9801, 1'b0, 1'b0, 24};
        vecs[4] = '{8'h00, 8'h73, 3'b011, 16'h0000, 1'b0, 1'b0, 24};
        vecs[5] = '{8'h99, 8'h99, 3'b001, 16'h0198, 1'b0, 1'b0, 18};
        vecs[6] = '{8'h1A, 8'h22, 3'b001, 16'h0000, 1'b0, 1'b1, 2};
        vecs[7] = '{8'h00, 8'h99, 3'b010, 16'h0099, 1'b1, 1'b0, 18};
        vecs[8] = '{8'h12, 8'h34, 3'b111, 16'h0000, 1'b0, 1'b1, 2};
        vecs[9] = '{8'h07, 8'h08, 3'b011, 16'h0056, 1'b0, 1'b0, 24};

        repeat (3) @(negedge i_Clk);
        check("reset_outputs", {12'd0, o_Busy, o_Done, o_Result_BCD, o_Negative, o_Error}, 32'(0));
        i_Rst_n = 1'b1;
        @(negedge i_Clk);

        for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Start re-pulsed with junk while busy and in DONE must be ignored.
        v = '{8'h21, 8'h34, 3'b011, 16'h0714, 1'b0, 1'b0, 24};
        run_op("noise_mul", v, 1'b1);
        v = '{8'h33, 8'h44, 3'b001, 16'h0077, 1'b0, 1'b0, 18};
        run_op("noise_add", v, 1'b1);

        // Reset during DABBLE aborts with no done.
        i_Operand_A = 8'h01; i_Operand_B = 8'h01; i_Op = 3'b001; i_Start = 1'b1;
        @(negedge i_Clk);
        i_Start = 1'b0;
        repeat (7) @(negedge i_Clk);
        i_Rst_n = 1'b0;
        @(negedge i_Clk);
        check("rst_mid_outputs", {12'd0, o_Busy, o_Done, o_Result_BCD, o_Negative, o_Error}, 32'(0));
        i_Rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_Clk);
            if (o_Done || o_Busy) seen++;
        end
        check("rst_mid_no_done", 32'(seen), 32'(0));
        v = '{8'h01, 8'h01, 3'b001, 16'h0002, 1'b0, 1'b0, 18};
        run_op("after_rst", v, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b;
            logic [2:0] op;
            int r;
            a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 9) == 0) a[3:0] = 4'($urandom_range(10, 15));
            r = $urandom_range(0, 9);
            op = (r < 8) ? 3'(r % 3 + 1) : 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d", i), model(a, b, op), i[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
